zero_count_norm_pipe: RTL and testbench
=======================================

Name: zero_count_norm_pipe

Overview:
- Pipelined, parametrised leading/trailing zero counter with an integrated normalising shifter and valid/ready handshake.
- Per-transaction mode selects the direction:
  - leading-zero count (LZ) with left normalisation, or
  - trailing-zero count (TZ) with right normalisation.
- Sits in the number-converter datapath ahead of exponent adjustment (float/posit/fixed conversion). A sideband tag travels with each word.

Parameters:
- WIDTH, 32, data width; power of two, 8..64.
- TAG_W, 8, sideband tag width (≥1); passed through unmodified.
- CNT_W, $clog2(WIDTH), count width; derived, not overridable.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept input this cycle.
- in_data  in  WIDTH  word to analyse.
- in_mode  in  1  0 = LZ (count from MSB), 1 = TZ (count from LSB).
- in_tag  in  TAG_W  sideband, returned with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_cnt  out  CNT_W  zero count in the selected direction.
- out_zero  out  1  in_data was all zeros.
- out_norm  out  WIDTH  LZ: in_data << cnt; TZ: in_data >> cnt.
- out_mode  out  1  echoed mode.
- out_tag  out  TAG_W  echoed tag.

Behaviour:
- Reset (async, while rst=1): all stage valid bits cleared; every output register cleared (out_valid=0, out_cnt=0, out_zero=0, out_norm=0, out_mode=0, out_tag=0). in_ready=1 after reset.
- Reset mid-operation: in-flight words are discarded, not completed. First accepted word after release appears normally.
- Pipeline: three register stages S1→S2→S3. Latency is exactly 3 cycles from input handshake to out_valid with no stall. Throughput is 1 word/cycle.
- Transfer rules:
  - Input transfer occurs on in_valid & in_ready.
  - Output transfer occurs on out_valid & out_ready.
  - Stage k loads when it is empty or stage k+1 loads/drains: adv3 = ~v3 | out_ready; adv2 = ~v2 | adv3; adv1 = ~v1 | adv2; in_ready = adv1.
  - in_ready is combinational from out_ready (no skid buffer).
- Stall: while out_valid & ~out_ready, all out_* hold stable and no stage with valid data is overwritten.
- S1 (group encode):
  - Split data into NG=WIDTH/4 nibbles.
  - Per nibble, compute a 2-bit count in the mode direction plus a zero flag.
  - Register data, mode, tag, counts, flags.
- S2 (combine):
  - Select the first non-zero nibble, scanning from the MSB nibble (LZ) or LSB nibble (TZ) by position index g.
  - cnt = 4*g + nibble count, CNT_W bits.
  - zero = all nibble flags set.
  - Register cnt, zero, data, mode, tag.
- S3 (normalise):
  - norm = LZ ? data << cnt : data >> cnt (logical, zero fill).
  - Register all out_* fields.
- All-zero input: out_zero=1, out_cnt=0, out_norm=0 (cnt does not saturate to WIDTH).
- Boundaries:
  - MSB set in LZ mode: cnt=0, norm=data.
  - LSB set in TZ mode: cnt=0, norm=data.
  - Only the opposite-end bit set: cnt=WIDTH-1, and norm has the single bit moved to the opposite end.
- Mode is sampled per word. Alternating modes back-to-back must not interact.
- in_data/in_mode/in_tag are don't-care when in_valid=0; out_* fields other than out_valid are don't-care when out_valid=0. They still reset to 0.

Decomposition:
- Package zc_pkg holds:
  - MODE_LZ=1'b0 and MODE_TZ=1'b1;
  - GROUP_W=4;
  - the parameter legality check (WIDTH power of two, 8..64), which is an elaboration-time error.
- One sub-module, zc_group4: combinational 4-bit encoder.
  - Inputs: nibble, dir.
  - Outputs: 2-bit count, zero.
  - Instantiated NG times in S1.
- The S2 priority selection and the S3 shifter stay in the top module.

Test Plan:
- LZ, WIDTH=32, in_data=0x0001_0000, tag=0x5A → 3 cycles later out_cnt=15, out_zero=0, out_norm=0x8000_0000, out_tag=0x5A.
- TZ, in_data=0x0001_0000 → out_cnt=16, out_norm=0x0000_0001. Then LZ 0x8000_0000 → cnt=0; TZ 0x8000_0000 → cnt=31, norm=0x0000_0001.
- in_data=0, both modes → out_zero=1, out_cnt=0, out_norm=0.
- 16 back-to-back words with out_ready=1 and random mode → 16 consecutive out_valid cycles, in order, matching the reference model; in_ready stays 1.
- out_ready held low for 5 cycles with a stream pending → exactly 3 words buffered, in_ready=0, out_* stable. Release → words drain in order with no loss or duplication.
- Assert rst for 1 cycle with 2 words in flight → out_valid=0 and all out_*=0 immediately. Next word after release appears 3 cycles after acceptance.

Source files
------------

// File: rtl/zc_pkg.sv
// Shared constants for the zero-count / normalise pipeline: mode encodings,
// nibble group width and the elaboration-time parameter legality check.
package zc_pkg;

  localparam logic MODE_LZ = 1'b0;
  localparam logic MODE_TZ = 1'b1;

  localparam int GROUP_W = 4;

  // WIDTH must be a power of two between 8 and 64 so that it splits into whole nibbles.
  function automatic bit width_legal(input int w);
    return (w >= 8) && (w <= 64) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/zc_group4.sv
// Combinational 4-bit zero encoder: counts zeros from the MSB (LZ) or the LSB (TZ)
// of one nibble and flags an all-zero nibble.
module zc_group4
  import zc_pkg::*;
(
  input  logic [GROUP_W-1:0] nibble_i,
  input  logic               dir_i,
  output logic [1:0]         cnt_o,
  output logic               zero_o
);

  // An all-zero nibble reports count 3; the combine stage skips it via zero_o.
  always_comb begin
    cnt_o  = 2'd0;
    zero_o = (nibble_i == '0);
    if (dir_i == MODE_LZ) begin
      if (nibble_i[3])      cnt_o = 2'd0;
      else if (nibble_i[2]) cnt_o = 2'd1;
      else if (nibble_i[1]) cnt_o = 2'd2;
      else                  cnt_o = 2'd3;
    end else begin
      if (nibble_i[0])      cnt_o = 2'd0;
      else if (nibble_i[1]) cnt_o = 2'd1;
      else if (nibble_i[2]) cnt_o = 2'd2;
      else                  cnt_o = 2'd3;
    end
  end

endmodule

// File: rtl/zero_count_norm_pipe.sv
// Three-stage leading/trailing zero counter with normalising shifter and a
// valid/ready handshake; a sideband tag rides along with every word.
module zero_count_norm_pipe
  import zc_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_mode,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NG = WIDTH / GROUP_W;

  if (!width_legal(WIDTH) || (TAG_W < 1)) begin : g_bad_param
    $error("zero_count_norm_pipe: WIDTH must be a power of two in 8..64 and TAG_W >= 1");
  end

  logic adv1, adv2, adv3;

  logic                   s1_valid_q;
  logic [WIDTH-1:0]       s1_data_q;
  logic                   s1_mode_q;
  logic [TAG_W-1:0]       s1_tag_q;
  logic [NG-1:0][1:0]     s1_gcnt_q;
  logic [NG-1:0]          s1_gzero_q;
  logic [NG-1:0][1:0]     gcnt_d;
  logic [NG-1:0]          gzero_d;

  logic                   s2_valid_q;
  logic [WIDTH-1:0]       s2_data_q;
  logic                   s2_mode_q;
  logic [TAG_W-1:0]       s2_tag_q;
  logic [CNT_W-1:0]       s2_cnt_q;
  logic                   s2_zero_q;
  logic [CNT_W-1:0]       s2_cnt_d;
  logic [CNT_W-1:0]       lz_cnt;
  logic [CNT_W-1:0]       tz_cnt;
  logic                   s2_zero_d;

  logic                   s3_valid_q;
  logic [WIDTH-1:0]       s3_norm_q;
  logic                   s3_mode_q;
  logic [TAG_W-1:0]       s3_tag_q;
  logic [CNT_W-1:0]       s3_cnt_q;
  logic                   s3_zero_q;
  logic [WIDTH-1:0]       s3_norm_d;

  // A stage may load when it is empty or its contents move on this cycle.
  assign adv3     = ~s3_valid_q | out_ready;
  assign adv2     = ~s2_valid_q | adv3;
  assign adv1     = ~s1_valid_q | adv2;
  assign in_ready = adv1;

  for (genvar g = 0; g < NG; g++) begin : g_group
    zc_group4 u_group (
      .nibble_i (in_data[g*GROUP_W +: GROUP_W]),
      .dir_i    (in_mode),
      .cnt_o    (gcnt_d[g]),
      .zero_o   (gzero_d[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= 1'b0;
      s1_tag_q   <= '0;
      s1_gcnt_q  <= '0;
      s1_gzero_q <= '0;
    end else begin
      if (adv1) s1_valid_q <= in_valid;
      if (adv1 && in_valid) begin
        s1_data_q  <= in_data;
        s1_mode_q  <= in_mode;
        s1_tag_q   <= in_tag;
        s1_gcnt_q  <= gcnt_d;
        s1_gzero_q <= gzero_d;
      end
    end
  end

  // Later loop iterations overwrite earlier ones, so LZ ends on the highest
  // non-zero nibble and TZ (scanned downwards) on the lowest.
  always_comb begin
    lz_cnt = '0;
    tz_cnt = '0;
    for (int i = 0; i < NG; i++) begin
      if (!s1_gzero_q[i])
        lz_cnt = CNT_W'((NG - 1 - i) * GROUP_W) + CNT_W'(s1_gcnt_q[i]);
    end
    for (int i = NG - 1; i >= 0; i--) begin
      if (!s1_gzero_q[i])
        tz_cnt = CNT_W'(i * GROUP_W) + CNT_W'(s1_gcnt_q[i]);
    end
    s2_zero_d = &s1_gzero_q;
    s2_cnt_d  = (s1_mode_q == MODE_TZ) ? tz_cnt : lz_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_mode_q  <= 1'b0;
      s2_tag_q   <= '0;
      s2_cnt_q   <= '0;
      s2_zero_q  <= 1'b0;
    end else begin
      if (adv2) s2_valid_q <= s1_valid_q;
      if (adv2 && s1_valid_q) begin
        s2_data_q <= s1_data_q;
        s2_mode_q <= s1_mode_q;
        s2_tag_q  <= s1_tag_q;
        s2_cnt_q  <= s2_cnt_d;
        s2_zero_q <= s2_zero_d;
      end
    end
  end

  // An all-zero word carries cnt=0 and data=0, so its norm is zero in either direction.
  always_comb begin
    s3_norm_d = (s2_mode_q == MODE_TZ) ? (s2_data_q >> s2_cnt_q) : (s2_data_q << s2_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
      s3_norm_q  <= '0;
      s3_mode_q  <= 1'b0;
      s3_tag_q   <= '0;
      s3_cnt_q   <= '0;
      s3_zero_q  <= 1'b0;
    end else begin
      if (adv3) s3_valid_q <= s2_valid_q;
      if (adv3 && s2_valid_q) begin
        s3_norm_q <= s3_norm_d;
        s3_mode_q <= s2_mode_q;
        s3_tag_q  <= s2_tag_q;
        s3_cnt_q  <= s2_cnt_q;
        s3_zero_q <= s2_zero_q;
      end
    end
  end

  assign out_valid = s3_valid_q;
  assign out_cnt   = s3_cnt_q;
  assign out_zero  = s3_zero_q;
  assign out_norm  = s3_norm_q;
  assign out_mode  = s3_mode_q;
  assign out_tag   = s3_tag_q;

endmodule

// File: tb/tb_zero_count_norm_pipe.sv
// Scoreboard bench for zero_count_norm_pipe: stimulus pushes reference results,
// a negedge monitor pops and compares every output transfer.
module tb_zero_count_norm_pipe;

  localparam int WIDTH = 32;
  localparam int TAG_W = 8;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_mode = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CNT_W-1:0] out_cnt;
  logic             out_zero;
  logic [WIDTH-1:0] out_norm;
  logic             out_mode;
  logic [TAG_W-1:0] out_tag;

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic             zero;
    logic [WIDTH-1:0] norm;
    logic             mode;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  int   runLen = 0;
  int   maxRun = 0;

  zero_count_norm_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt   (out_cnt),
    .out_zero  (out_zero),
    .out_norm  (out_norm),
    .out_mode  (out_mode),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  // Reference: count zeros arithmetically, then shift the word by that amount.
  function automatic exp_t refModel(input logic [WIDTH-1:0] d, input logic m,
                                    input logic [TAG_W-1:0] t);
    exp_t e;
    longint unsigned v;
    int n;
    v = 64'(d);
    n = 0;
    if (v == 0) begin
      e.cnt  = '0;
      e.zero = 1'b1;
      e.norm = '0;
    end else begin
      if (m == 1'b0) begin
        while (v < (64'd1 << (WIDTH - 1 - n))) n++;
      end else begin
        while (((v >> n) % 2) == 0) n++;
      end
      e.cnt  = CNT_W'(n);
      e.zero = 1'b0;
      e.norm = m ? (d >> n) : (d << n);
    end
    e.mode = m;
    e.tag  = t;
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] randWord();
    logic [WIDTH-1:0] w;
    case ($urandom_range(0, 4))
      0:       w = '0;
      1:       w = 32'd1 << $urandom_range(0, WIDTH - 1);
      2:       w = 32'($urandom) >> $urandom_range(0, WIDTH - 1);
      3:       w = 32'($urandom) << $urandom_range(0, WIDTH - 1);
      default: w = 32'($urandom);
    endcase
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Holds one word on the input until it is accepted; caller sits just after a rising edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic m,
                               input logic [TAG_W-1:0] t, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    in_data  = d;
    in_mode  = m;
    in_tag   = t;
    in_valid = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        expQ.push_back(refModel(d, m, t));
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=no_accept required=accept");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic checkLatency(input string name, output bit seen);
    int n;
    n = 0;
    seen = 1'b0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        n = k;
      end
    end
    checkOutput(name, 64'(n), 64'd3);
  endtask

  task automatic directed(input string name, input logic [WIDTH-1:0] d, input logic m,
                          input logic [TAG_W-1:0] t, input int reqCnt, input bit reqZero,
                          input logic [WIDTH-1:0] reqNorm);
    int  w;
    bit  seen;
    applyStimulus(d, m, t, w);
    checkLatency({name, "_latency"}, seen);
    if (seen) begin
      checkOutput({name, "_cnt"},  64'(out_cnt),  64'(reqCnt));
      checkOutput({name, "_zero"}, 64'(out_zero), 64'(reqZero));
      checkOutput({name, "_norm"}, 64'(out_norm), 64'(reqNorm));
      checkOutput({name, "_tag"},  64'(out_tag),  64'(t));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200 && expQ.size() != 0; k++) @(negedge clk);
    checkOutput({name, "_pending"}, 64'(expQ.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      runLen++;
      if (runLen > maxRun) maxRun = runLen;
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output actual=out_valid required=no_output tag=0x%0h", out_tag);
      end else begin
        monExp = expQ.pop_front();
        pops++;
        checkOutput("mon_cnt",  64'(out_cnt),  64'(monExp.cnt));
        checkOutput("mon_zero", 64'(out_zero), 64'(monExp.zero));
        checkOutput("mon_norm", 64'(out_norm), 64'(monExp.norm));
        checkOutput("mon_mode", 64'(out_mode), 64'(monExp.mode));
        checkOutput("mon_tag",  64'(out_tag),  64'(monExp.tag));
      end
    end else begin
      runLen = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   w;
    int   waitSum;
    int   popsBefore;
    bit   seen;
    exp_t e1;

    #12;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_cnt",   64'(out_cnt),   64'd0);
    checkOutput("reset_out_norm",  64'(out_norm),  64'd0);
    checkOutput("reset_out_tag",   64'(out_tag),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

    directed("lz_bit16",   32'h0001_0000, 1'b0, 8'h5A, 15, 1'b0, 32'h8000_0000);
    directed("tz_bit16",   32'h0001_0000, 1'b1, 8'h11, 16, 1'b0, 32'h0000_0001);
    directed("lz_msb",     32'h8000_0000, 1'b0, 8'h22, 0,  1'b0, 32'h8000_0000);
    directed("tz_msb",     32'h8000_0000, 1'b1, 8'h33, 31, 1'b0, 32'h0000_0001);
    directed("tz_lsb",     32'h0000_0001, 1'b1, 8'h44, 0,  1'b0, 32'h0000_0001);
    directed("lz_lsb",     32'h0000_0001, 1'b0, 8'h55, 31, 1'b0, 32'h8000_0000);
    directed("lz_zero",    32'h0000_0000, 1'b0, 8'h66, 0,  1'b1, 32'h0000_0000);
    directed("tz_zero",    32'h0000_0000, 1'b1, 8'h77, 0,  1'b1, 32'h0000_0000);
    directed("tz_mixed",   32'h00F0_0300, 1'b1, 8'h88, 8,  1'b0, 32'h0000_F003);
    drain("directed");

    // Back-to-back burst with random modes and full downstream acceptance.
    maxRun  = 0;
    waitSum = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(randWord(), 1'($urandom_range(0, 1)), 8'($urandom), w);
      waitSum += w;
    end
    drain("burst");
    checkOutput("burst_in_ready_stalls", 64'(waitSum), 64'd0);
    checkOutput("burst_consecutive_out", 64'(maxRun), 64'd16);

    // Backpressure: three words fill the pipe, a fourth must wait.
    out_ready = 1'b0;
    e1 = refModel(32'h0000_0F00, 1'b0, 8'hA1);
    popsBefore = pops;
    applyStimulus(32'h0000_0F00, 1'b0, 8'hA1, w);
    applyStimulus(32'h1234_0000, 1'b1, 8'hA2, w);
    applyStimulus(32'h0000_0000, 1'b0, 8'hA3, w);
    in_data  = 32'h0400_0000;
    in_mode  = 1'b1;
    in_tag   = 8'hA4;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready",  64'(in_ready),  64'd0);
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_out_tag",   64'(out_tag),   64'(e1.tag));
      checkOutput("stall_out_norm",  64'(out_norm),  64'(e1.norm));
      checkOutput("stall_out_cnt",   64'(out_cnt),   64'(e1.cnt));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(32'h0400_0000, 1'b1, 8'hA4, w);
    drain("stall");
    checkOutput("stall_drained_words", 64'(pops - popsBefore), 64'd4);

    // Random traffic with random downstream backpressure.
    fork
      begin
        for (int i = 0; i < 60; i++)
          applyStimulus(randWord(), 1'($urandom_range(0, 1)), 8'($urandom), w);
      end
      begin
        for (int i = 0; i < 400; i++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain("random");

    // Reset with two words in flight discards them immediately.
    applyStimulus(32'h0000_8000, 1'b1, 8'hC1, w);
    applyStimulus(32'h00FF_0000, 1'b0, 8'hC2, w);
    rst = 1'b1;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_out_cnt",   64'(out_cnt),   64'd0);
    checkOutput("midreset_out_zero",  64'(out_zero),  64'd0);
    checkOutput("midreset_out_norm",  64'(out_norm),  64'd0);
    checkOutput("midreset_out_mode",  64'(out_mode),  64'd0);
    checkOutput("midreset_out_tag",   64'(out_tag),   64'd0);
    expQ.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(32'h0000_0100, 1'b0, 8'hD1, w);
    checkLatency("post_reset_latency", seen);
    if (seen) checkOutput("post_reset_cnt", 64'(out_cnt), 64'd23);
    drain("post_reset");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
